// File: rtl/controlador_de_interrupcao.sv
`default_nettype none
// ============================================================================
// Module   : controlador_de_interrupcao
// Brief    : Interrupt controller. Tracks kernel/user mode, preempts user
//            programs with a quantum timer, latches I/O and program-end
//            events and presents a one-cycle interrupt pulse with a held
//            interrupt code and interrupted PC until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_de_interrupcao #(
    parameter int QUANTUM = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_user_mode,
    input  logic        i_kernel_mode,
    input  logic        i_clear_intr,
    input  logic        i_halt_req,
    input  logic        i_io_req,
    input  logic [31:0] i_pc_in,
    output logic        o_intr,
    output logic [31:0] o_intr_code,
    output logic [31:0] o_intr_pc,
    output logic        o_user_active
);

    typedef enum logic [1:0] {
        S_KERNEL  = 2'd0,
        S_USER    = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    localparam logic [15:0] c_Q_LAST    = 16'(QUANTUM - 1);
    localparam logic [31:0] c_CODE_NONE = 32'd0;
    localparam logic [31:0] c_CODE_QUAN = 32'd1;
    localparam logic [31:0] c_CODE_IO   = 32'd2;
    localparam logic [31:0] c_CODE_END  = 32'd3;

    state_t      r_state;
    logic [15:0] r_qcnt;
    logic        r_io_pending;
    logic        r_io_req_d;
    logic        r_intr;
    logic [31:0] r_intr_code;
    logic [31:0] r_intr_pc;
    logic        r_user_active;

    state_t      w_state_nxt;
    logic [15:0] w_qcnt_nxt;
    logic        w_io_pend_nxt;
    logic        w_intr_nxt;
    logic [31:0] w_code_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_io_edge;
    logic        w_io_any;
    logic        w_expiry;

    // An I/O edge seen this cycle counts as pending immediately.
    assign w_io_edge = i_io_req & ~r_io_req_d;
    assign w_io_any  = r_io_pending | w_io_edge;
    assign w_expiry  = (r_qcnt == c_Q_LAST);

    // State register and registered outputs; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_KERNEL;
            r_qcnt        <= 16'd0;
            r_io_pending  <= 1'b0;
            r_io_req_d    <= 1'b0;
            r_intr        <= 1'b0;
            r_intr_code   <= c_CODE_NONE;
            r_intr_pc     <= 32'd0;
            r_user_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_qcnt        <= w_qcnt_nxt;
            r_io_pending  <= w_io_pend_nxt;
            r_io_req_d    <= i_io_req;
            r_intr        <= w_intr_nxt;
            r_intr_code   <= w_code_nxt;
            r_intr_pc     <= w_pc_nxt;
            r_user_active <= (w_state_nxt == S_USER);
        end
    end

    // Next-state, quantum counter and event capture, in priority order.
    always_comb begin
        w_state_nxt   = r_state;
        w_qcnt_nxt    = r_qcnt;
        w_io_pend_nxt = w_io_any;
        w_intr_nxt    = 1'b0;
        w_code_nxt    = r_intr_code;
        w_pc_nxt      = r_intr_pc;
        case (r_state)
            S_KERNEL: begin
                if (i_user_mode && !i_kernel_mode) begin
                    w_state_nxt = S_USER;
                    w_qcnt_nxt  = 16'd0;
                end
            end
            S_USER: begin
                if (i_kernel_mode) begin
                    // Voluntary return: a coincident expiry is dropped.
                    w_state_nxt = S_KERNEL;
                end else if (i_halt_req) begin
                    w_state_nxt = S_PENDING;
                    w_intr_nxt  = 1'b1;
                    w_code_nxt  = c_CODE_END;
                    w_pc_nxt    = i_pc_in;
                end else if (w_io_any) begin
                    w_state_nxt   = S_PENDING;
                    w_intr_nxt    = 1'b1;
                    w_code_nxt    = c_CODE_IO;
                    w_pc_nxt      = i_pc_in;
                    w_io_pend_nxt = 1'b0;
                end else if (w_expiry) begin
                    w_state_nxt = S_PENDING;
                    w_intr_nxt  = 1'b1;
                    w_code_nxt  = c_CODE_QUAN;
                    w_pc_nxt    = i_pc_in;
                end else if (i_user_mode) begin
                    w_qcnt_nxt = 16'd0;
                end else begin
                    w_qcnt_nxt = r_qcnt + 16'd1;
                end
            end
            S_PENDING: begin
                // Only an acknowledge leaves; intrPc stays for software.
                if (i_clear_intr) begin
                    w_code_nxt = c_CODE_NONE;
                    if (i_user_mode && !i_kernel_mode) begin
                        w_state_nxt = S_USER;
                        w_qcnt_nxt  = 16'd0;
                    end else begin
                        w_state_nxt = S_KERNEL;
                    end
                end
            end
            default: begin
                w_state_nxt = S_KERNEL;
            end
        endcase
    end

    assign o_intr        = r_intr;
    assign o_intr_code   = r_intr_code;
    assign o_intr_pc     = r_intr_pc;
    assign o_user_active = r_user_active;

endmodule
`default_nettype wire

// File: tb/tb_controlador_de_interrupcao.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_de_interrupcao
// Brief    : Self-checking bench; expected interrupts are queued when the
//            provoking stimulus is driven and compared when intr fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_de_interrupcao;

    localparam int c_QUANTUM = 4;

    logic        clk;
    logic        rst_n;
    logic        r_user_mode;
    logic        r_kernel_mode;
    logic        r_clear_intr;
    logic        r_halt_req;
    logic        r_io_req;
    logic [31:0] r_pc_in;
    logic        w_intr;
    logic [31:0] w_intr_code;
    logic [31:0] w_intr_pc;
    logic        w_user_active;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    controlador_de_interrupcao #(.QUANTUM(c_QUANTUM)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_user_mode   (r_user_mode),
        .i_kernel_mode (r_kernel_mode),
        .i_clear_intr  (r_clear_intr),
        .i_halt_req    (r_halt_req),
        .i_io_req      (r_io_req),
        .i_pc_in       (r_pc_in),
        .o_intr        (w_intr),
        .o_intr_code   (w_intr_code),
        .o_intr_pc     (w_intr_pc),
        .o_user_active (w_user_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] code, input logic [31:0] pc);
        exp_t e;
        e.code = code;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    // Steps until intr is seen (bounded) and checks the edge count.
    task automatic wait_intr(input string tag, input int lat);
        int n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (w_intr) begin
                n = i;
                break;
            end
        end
        chk(tag, n, lat);
    endtask

    // Scoreboard: every intr pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (w_intr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_intr", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_code", w_intr_code, e.code);
                chk("sb_pc", w_intr_pc, e.pc);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        r_user_mode   = 1'b0;
        r_kernel_mode = 1'b0;
        r_clear_intr  = 1'b0;
        r_halt_req    = 1'b0;
        r_io_req      = 1'b0;
        r_pc_in       = 32'h0;

        // Reset values
        #12;
        chk("rst_intr", {31'd0, w_intr}, 32'd0);
        chk("rst_code", w_intr_code, 32'd0);
        chk("rst_pc", w_intr_pc, 32'd0);
        chk("rst_user", {31'd0, w_user_active}, 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("idle_user", {31'd0, w_user_active}, 32'd0);

        // Quantum preemption
        r_pc_in = 32'h40;
        r_user_mode = 1'b1;
        push(32'd1, 32'h40);
        step();
        r_user_mode = 1'b0;
        chk("q_user_active", {31'd0, w_user_active}, 32'd1);
        wait_intr("q_latency", c_QUANTUM);
        chk("q_code", w_intr_code, 32'd1);
        step();
        chk("q_intr_drop", {31'd0, w_intr}, 32'd0);
        chk("q_code_held", w_intr_code, 32'd1);
        chk("q_pend_user", {31'd0, w_user_active}, 32'd0);
        r_clear_intr = 1'b1;
        step();
        r_clear_intr = 1'b0;
        chk("q_clr_code", w_intr_code, 32'd0);
        chk("q_clr_pc_held", w_intr_pc, 32'h40);
        chk("q_clr_user", {31'd0, w_user_active}, 32'd0);

        // Priority: halt beats a same-cycle I/O edge; I/O stays pending
        r_user_mode = 1'b1;
        step();
        r_user_mode = 1'b0;
        r_halt_req = 1'b1;
        r_io_req   = 1'b1;
        r_pc_in    = 32'h80;
        push(32'd3, 32'h80);
        step();
        r_halt_req = 1'b0;
        r_io_req   = 1'b0;
        chk("pri_intr", {31'd0, w_intr}, 32'd1);
        chk("pri_code", w_intr_code, 32'd3);
        step();
        r_clear_intr = 1'b1;
        r_user_mode  = 1'b1;
        r_pc_in      = 32'h90;
        push(32'd2, 32'h90);
        step();
        r_clear_intr = 1'b0;
        r_user_mode  = 1'b0;
        chk("pri_resume_code", w_intr_code, 32'd0);
        chk("pri_resume_user", {31'd0, w_user_active}, 32'd1);
        wait_intr("pri_io_latency", 1);
        chk("pri_io_code", w_intr_code, 32'd2);
        step();
        r_clear_intr = 1'b1;
        step();
        r_clear_intr = 1'b0;

        // Syscall on the expiry cycle suppresses the timer event
        r_user_mode = 1'b1;
        step();
        r_user_mode = 1'b0;
        for (int i = 0; i < c_QUANTUM - 1; i++) step();
        r_kernel_mode = 1'b1;
        step();
        r_kernel_mode = 1'b0;
        chk("sys_intr", {31'd0, w_intr}, 32'd0);
        chk("sys_user", {31'd0, w_user_active}, 32'd0);
        chk("sys_code", w_intr_code, 32'd0);
        for (int i = 0; i < 6; i++) step();

        // I/O edge latched in kernel, delivered on entry to user
        r_io_req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        r_pc_in = 32'hA0;
        r_user_mode = 1'b1;
        push(32'd2, 32'hA0);
        step();
        r_user_mode = 1'b0;
        wait_intr("io_k_latency", 1);
        chk("io_k_code", w_intr_code, 32'd2);
        step();
        r_clear_intr = 1'b1;
        step();
        r_clear_intr = 1'b0;
        r_user_mode = 1'b1;
        step();
        r_user_mode = 1'b0;
        for (int i = 0; i < c_QUANTUM - 1; i++) step();
        chk("io_held_no_2nd", {31'd0, w_intr}, 32'd0);
        chk("io_held_user", {31'd0, w_user_active}, 32'd1);
        r_kernel_mode = 1'b1;
        step();
        r_kernel_mode = 1'b0;
        r_io_req = 1'b0;
        step();

        // Asynchronous reset while a quantum event is pending
        r_pc_in = 32'h40;
        r_user_mode = 1'b1;
        push(32'd1, 32'h40);
        step();
        r_user_mode = 1'b0;
        wait_intr("ar_latency", c_QUANTUM);
        step();
        chk("ar_pend_code", w_intr_code, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_code", w_intr_code, 32'd0);
        chk("ar_pc", w_intr_pc, 32'd0);
        chk("ar_intr", {31'd0, w_intr}, 32'd0);
        step();
        #1 rst_n = 1'b1;
        r_clear_intr = 1'b1;
        step();
        r_clear_intr = 1'b0;
        chk("ar_clr_code", w_intr_code, 32'd0);
        chk("ar_clr_user", {31'd0, w_user_active}, 32'd0);
        for (int i = 0; i < 6; i++) step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
